// File: rtl/regs_wb_arbiter_if.sv
// Register-file writeback bus: two requester ports (A in-order, B buffered)
// plus the single arbitrated register-file write port.
interface regs_wb_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             a_valid;
  logic             a_ready;
  logic [5:0]       a_addr;
  logic [31:0]      a_data;
  logic [31:0]      a_data2;
  logic             a_mop;

  logic             b_valid;
  logic             b_ready;
  logic [5:0]       b_addr;
  logic [31:0]      b_data;
  logic [31:0]      b_data2;
  logic             b_mop;

  logic             w_regs_en;
  logic [5:0]       w_regs_addr;
  logic [31:0]      w_regs_data;
  logic [31:0]      w_regs_data2;
  logic             w_regs_mop_en;
  logic             ctrl_stall;
  logic [CNT_W-1:0] b_count;

  modport slave (
    input  a_valid, a_addr, a_data, a_data2, a_mop,
    input  b_valid, b_addr, b_data, b_data2, b_mop,
    output a_ready, b_ready,
    output w_regs_en, w_regs_addr, w_regs_data, w_regs_data2, w_regs_mop_en,
    output ctrl_stall, b_count
  );

  modport master (
    output a_valid, a_addr, a_data, a_data2, a_mop,
    output b_valid, b_addr, b_data, b_data2, b_mop,
    input  a_ready, b_ready,
    input  w_regs_en, w_regs_addr, w_regs_data, w_regs_data2, w_regs_mop_en,
    input  ctrl_stall, b_count
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Two-port writeback arbiter for the register-file write port: port A has
// priority, port B is FIFO-buffered and forced through after MAX_WAIT losses.
module regs_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  regs_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] data2;
    logic        mop;
  } wb_req_t;

  wb_req_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       starve_q;

  logic             b_empty;
  logic             b_ready_int;
  logic             force_b;
  logic             grant_a;
  logic             grant_b;
  logic             push;
  wb_req_t          a_req;
  wb_req_t          sel_req;

  logic             w_en_q;
  logic             w_mop_q;
  logic [5:0]       w_addr_q;
  logic [31:0]      w_data_q;
  logic [31:0]      w_data2_q;

  always_comb begin
    b_empty     = (cnt_q == '0);
    b_ready_int = (cnt_q < CNT_W'(FIFO_DEPTH));
    force_b     = !b_empty && (starve_q >= 4'(MAX_WAIT));
    grant_b     = !b_empty && (force_b || !bus.a_valid);
    grant_a     = bus.a_valid && !force_b;
    push        = bus.b_valid && b_ready_int;
    a_req       = {bus.a_addr, bus.a_data, bus.a_data2, bus.a_mop};
    sel_req     = grant_b ? fifo_mem[rd_ptr_q] : a_req;
  end

  assign bus.a_ready    = !force_b;
  assign bus.b_ready    = b_ready_int;
  assign bus.ctrl_stall = bus.a_valid && force_b;
  assign bus.b_count    = cnt_q;

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.b_addr, bus.b_data, bus.b_data2, bus.b_mop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (grant_b) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(grant_b);
      if (grant_b || b_empty) begin
        starve_q <= '0;
      end else if (starve_q < 4'(MAX_WAIT)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en_q    <= 1'b0;
      w_mop_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_data2_q <= '0;
    end else if (grant_a || grant_b) begin
      w_en_q    <= (sel_req.addr != 6'd0);
      w_mop_q   <= sel_req.mop && (sel_req.addr != 6'd0);
      w_addr_q  <= sel_req.addr;
      w_data_q  <= sel_req.data;
      w_data2_q <= sel_req.data2;
    end else begin
      w_en_q  <= 1'b0;
      w_mop_q <= 1'b0;
    end
  end

  assign bus.w_regs_en     = w_en_q;
  assign bus.w_regs_mop_en = w_mop_q;
  assign bus.w_regs_addr   = w_addr_q;
  assign bus.w_regs_data   = w_data_q;
  assign bus.w_regs_data2  = w_data2_q;
endmodule
